// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-op and sequencer-state definitions for the 4-bit-opcode CPU.
package cpu_pkg;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned STATE_W  = 3;
   localparam int unsigned ALU_OP_W = 2;

   typedef enum logic [OPCODE_W-1:0] {
      OP_LB   = 4'd0,
      OP_LHB  = 4'd1,
      OP_JMP  = 4'd2,
      OP_STR  = 4'd3,
      OP_LIM  = 4'd4,
      OP_MVB  = 4'd5,
      OP_MVF  = 4'd6,
      OP_ADD  = 4'd7,
      OP_SUB  = 4'd8,
      OP_SFT  = 4'd9,
      OP_BNE  = 4'd10,
      OP_BEQ  = 4'd11,
      OP_BLT  = 4'd12,
      OP_INC  = 4'd13,
      OP_HALT = 4'd14,
      OP_TBA  = 4'd15
   } opcode_t;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_SFT = 2'd2,
      ALU_INC = 2'd3
   } alu_op_t;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALTED = 3'd6
   } seq_state_t;

   function automatic logic is_alu(input opcode_t op);
      return op inside {OP_ADD, OP_SUB, OP_SFT, OP_INC};
   endfunction

   function automatic logic is_branch(input opcode_t op);
      return op inside {OP_BNE, OP_BEQ, OP_BLT};
   endfunction

   function automatic logic is_mem(input opcode_t op);
      return op inside {OP_LB, OP_LHB, OP_STR};
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits for ready; flags when the timeout limit is reached.
module mem_wait_timer #(
   parameter int unsigned TMO_W       = 8,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam logic [TMO_W-1:0] LIMIT = TMO_W'(MEM_TIMEOUT);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   // Counter parks at the limit so it cannot wrap back below it.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the 4-bit-opcode CPU.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TMO_W       = 8,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic             imm_flag,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_sel_inst,
   output logic             ir_load,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             alu_en,
   output logic             reg_we,
   output logic             halted,
   output logic             fault,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] instr_count
);

   seq_state_t       state_q, state_d;
   opcode_t          op_q, op_d;
   logic             imm_q, imm_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic             fault_q, fault_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic             mem_sel_inst_q, mem_sel_inst_d;
   logic             alu_en_q, alu_en_d;
   logic             reg_we_q, reg_we_d;
   logic             halted_q, halted_d;
   logic             tmr_clear, tmr_count, tmr_expired;
   logic             unused_imm;

   // imm_flag is held for the datapath; sequencing never depends on it.
   assign unused_imm = imm_q;

   mem_wait_timer #(
      .TMO_W       (TMO_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (tmr_clear),
      .count_en (tmr_count),
      .expired  (tmr_expired)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      imm_d         = imm_q;
      instr_count_d = instr_count_q;
      fault_d       = fault_q;
      ir_load       = 1'b0;
      pc_inc        = 1'b0;
      pc_load       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = S_DECODE;
            end else if (tmr_expired) begin
               fault_d = 1'b1;
               state_d = S_HALTED;
            end
         end
         S_DECODE: begin
            op_d  = opcode_t'(opcode);
            imm_d = imm_flag;
            if (op_d == OP_HALT) begin
               state_d = S_HALTED;
            end else begin
               if (instr_count_q != '1) instr_count_d = instr_count_q + CNT_W'(1);
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_alu(op_q)) begin
               state_d = S_WB;
            end else if (is_branch(op_q)) begin
               pc_load = branch_taken;
               state_d = S_FETCH;
            end else if (op_q == OP_JMP) begin
               pc_load = 1'b1;
               state_d = S_FETCH;
            end else if (is_mem(op_q)) begin
               state_d = S_MEM;
            end else if (op_q inside {OP_MVB, OP_MVF, OP_LIM}) begin
               state_d = S_WB;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = (op_q == OP_STR) ? S_FETCH : S_WB;
            end else if (tmr_expired) begin
               fault_d = 1'b1;
               state_d = S_HALTED;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         S_HALTED: begin
            if (start) begin
               fault_d = 1'b0;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Moore strobes are registered by looking ahead at the next state.
      mem_req_d      = (state_d == S_FETCH) || (state_d == S_MEM);
      mem_sel_inst_d = (state_d == S_FETCH);
      mem_we_d       = (state_d == S_MEM) && (op_d == OP_STR);
      alu_en_d       = (state_d == S_EXEC) && (is_alu(op_d) || is_branch(op_d));
      reg_we_d       = (state_d == S_WB);
      halted_d       = (state_d == S_HALTED);

      tmr_clear = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));
      tmr_count = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         op_q           <= OP_LB;
         imm_q          <= 1'b0;
         instr_count_q  <= '0;
         fault_q        <= 1'b0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_sel_inst_q <= 1'b0;
         alu_en_q       <= 1'b0;
         reg_we_q       <= 1'b0;
         halted_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         imm_q          <= imm_d;
         instr_count_q  <= instr_count_d;
         fault_q        <= fault_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_sel_inst_q <= mem_sel_inst_d;
         alu_en_q       <= alu_en_d;
         reg_we_q       <= reg_we_d;
         halted_q       <= halted_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_sel_inst = mem_sel_inst_q;
   assign alu_en       = alu_en_q;
   assign reg_we       = reg_we_q;
   assign halted       = halted_q;
   assign fault        = fault_q;
   assign state_o      = state_q;
   assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed cycle-by-cycle bench for cpu_sequencer with a short memory timeout.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  opcode;
   logic        imm_flag;
   logic        branch_taken;
   logic        mem_ready;
   logic        mem_req, mem_we, mem_sel_inst, ir_load, pc_inc, pc_load;
   logic        alu_en, reg_we, halted, fault;
   logic [2:0]  state_o;
   logic [15:0] instr_count;

   int total = 0;
   int bad   = 0;

   // Strobe vector: {mem_req, mem_sel_inst, mem_we, ir_load, pc_inc, pc_load, alu_en, reg_we, halted, fault}
   localparam logic [9:0] V_NONE = 10'b0000000000;
   localparam logic [9:0] V_FR   = 10'b1101100000;
   localparam logic [9:0] V_FW   = 10'b1100000000;
   localparam logic [9:0] V_ALU  = 10'b0000001000;
   localparam logic [9:0] V_BT   = 10'b0000011000;
   localparam logic [9:0] V_JMP  = 10'b0000010000;
   localparam logic [9:0] V_WB   = 10'b0000000100;
   localparam logic [9:0] V_LD   = 10'b1000000000;
   localparam logic [9:0] V_ST   = 10'b1010000000;
   localparam logic [9:0] V_HLT  = 10'b0000000010;
   localparam logic [9:0] V_HF   = 10'b0000000011;

   typedef struct packed {
      logic [3:0] op;
      logic       rdy;
      logic       bt;
      logic       start;
      logic [2:0] st;
      logic [9:0] vec;
   } step_t;

   cpu_sequencer #(
      .CNT_W       (16),
      .TMO_W       (8),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .opcode       (opcode),
      .imm_flag     (imm_flag),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_sel_inst (mem_sel_inst),
      .ir_load      (ir_load),
      .pc_inc       (pc_inc),
      .pc_load      (pc_load),
      .alu_en       (alu_en),
      .reg_we       (reg_we),
      .halted       (halted),
      .fault        (fault),
      .state_o      (state_o),
      .instr_count  (instr_count)
   );

   always #5 clk = ~clk;

   function automatic step_t mk(input logic [3:0] op, input logic rdy, input logic bt,
                                input logic st_in, input logic [2:0] st, input logic [9:0] vec);
      step_t s;
      s.op = op; s.rdy = rdy; s.bt = bt; s.start = st_in; s.st = st; s.vec = vec;
      return s;
   endfunction

   function automatic logic [9:0] obs_vec();
      return {mem_req, mem_sel_inst, mem_we, ir_load, pc_inc, pc_load, alu_en, reg_we, halted, fault};
   endfunction

   task automatic drive(input step_t s);
      opcode = s.op; mem_ready = s.rdy; branch_taken = s.bt; start = s.start;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; opcode = 4'd0; imm_flag = 1'b0;
      branch_taken = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (state_o !== 3'd0 || obs_vec() !== V_NONE || instr_count !== 16'd0) begin
         bad++;
         $display("FAIL reset: state=%0d strobes=%b count=%0d expected 0/%b/0", state_o, obs_vec(), instr_count, V_NONE);
      end
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_alu();
      step_t seq [5];
      seq = '{mk(4'd7,1,0,1,3'd0,V_NONE), mk(4'd7,1,0,1,3'd1,V_FR), mk(4'd7,1,0,1,3'd2,V_NONE),
              mk(4'd7,1,0,1,3'd3,V_ALU),  mk(4'd7,1,0,1,3'd5,V_WB)};
      for (int i = 0; i < 5; i++) begin
         drive(seq[i]);
         @(negedge clk);
         total++;
         if (state_o !== seq[i].st || obs_vec() !== seq[i].vec) begin
            bad++;
            $display("FAIL alu[%0d]: state=%0d strobes=%b expected state=%0d strobes=%b", i, state_o, obs_vec(), seq[i].st, seq[i].vec);
         end
         next_cycle();
      end
      start = 1'b0;
      total++;
      if (instr_count !== 16'd1) begin
         bad++;
         $display("FAIL alu_count: got %0d expected 1", instr_count);
      end
   endtask

   task automatic test_load_store();
      step_t seq [12];
      seq = '{mk(4'd0,1,0,0,3'd1,V_FR), mk(4'd0,1,0,0,3'd2,V_NONE), mk(4'd0,1,0,0,3'd3,V_NONE),
              mk(4'd0,0,0,0,3'd4,V_LD), mk(4'd0,0,0,0,3'd4,V_LD),   mk(4'd0,0,0,0,3'd4,V_LD),
              mk(4'd0,1,0,0,3'd4,V_LD), mk(4'd0,1,0,0,3'd5,V_WB),
              mk(4'd3,1,0,0,3'd1,V_FR), mk(4'd3,1,0,0,3'd2,V_NONE), mk(4'd3,1,0,0,3'd3,V_NONE),
              mk(4'd3,1,0,0,3'd4,V_ST)};
      for (int i = 0; i < 12; i++) begin
         drive(seq[i]);
         @(negedge clk);
         total++;
         if (state_o !== seq[i].st || obs_vec() !== seq[i].vec) begin
            bad++;
            $display("FAIL load_store[%0d]: state=%0d strobes=%b expected state=%0d strobes=%b", i, state_o, obs_vec(), seq[i].st, seq[i].vec);
         end
         next_cycle();
      end
      total++;
      if (instr_count !== 16'd3) begin
         bad++;
         $display("FAIL load_store_count: got %0d expected 3", instr_count);
      end
   endtask

   task automatic test_branch();
      step_t seq [6];
      seq = '{mk(4'd11,1,1,0,3'd1,V_FR), mk(4'd11,1,1,0,3'd2,V_NONE), mk(4'd11,1,1,0,3'd3,V_BT),
              mk(4'd10,1,0,0,3'd1,V_FR), mk(4'd10,1,0,0,3'd2,V_NONE), mk(4'd10,1,0,0,3'd3,V_ALU)};
      for (int i = 0; i < 6; i++) begin
         drive(seq[i]);
         @(negedge clk);
         total++;
         if (state_o !== seq[i].st || obs_vec() !== seq[i].vec) begin
            bad++;
            $display("FAIL branch[%0d]: state=%0d strobes=%b expected state=%0d strobes=%b", i, state_o, obs_vec(), seq[i].st, seq[i].vec);
         end
         next_cycle();
      end
      total++;
      if (instr_count !== 16'd5) begin
         bad++;
         $display("FAIL branch_count: got %0d expected 5", instr_count);
      end
   endtask

   task automatic test_back_to_back();
      step_t seq [10];
      seq = '{mk(4'd2,1,0,0,3'd1,V_FR),  mk(4'd2,1,0,0,3'd2,V_NONE),  mk(4'd2,1,0,0,3'd3,V_JMP),
              mk(4'd15,1,1,0,3'd1,V_FR), mk(4'd15,1,1,0,3'd2,V_NONE), mk(4'd15,1,1,0,3'd3,V_NONE),
              mk(4'd5,1,1,0,3'd1,V_FR),  mk(4'd5,1,1,0,3'd2,V_NONE),  mk(4'd5,1,1,0,3'd3,V_NONE),
              mk(4'd5,1,1,0,3'd5,V_WB)};
      for (int i = 0; i < 10; i++) begin
         drive(seq[i]);
         @(negedge clk);
         total++;
         if (state_o !== seq[i].st || obs_vec() !== seq[i].vec) begin
            bad++;
            $display("FAIL back_to_back[%0d]: state=%0d strobes=%b expected state=%0d strobes=%b", i, state_o, obs_vec(), seq[i].st, seq[i].vec);
         end
         next_cycle();
      end
      total++;
      if (instr_count !== 16'd8) begin
         bad++;
         $display("FAIL back_to_back_count: got %0d expected 8", instr_count);
      end
   endtask

   task automatic test_halt();
      step_t seq [5];
      seq = '{mk(4'd14,1,0,0,3'd1,V_FR),  mk(4'd14,1,0,0,3'd2,V_NONE), mk(4'd14,1,0,0,3'd6,V_HLT),
              mk(4'd14,0,0,0,3'd6,V_HLT), mk(4'd14,0,0,1,3'd6,V_HLT)};
      for (int i = 0; i < 5; i++) begin
         drive(seq[i]);
         @(negedge clk);
         total++;
         if (state_o !== seq[i].st || obs_vec() !== seq[i].vec) begin
            bad++;
            $display("FAIL halt[%0d]: state=%0d strobes=%b expected state=%0d strobes=%b", i, state_o, obs_vec(), seq[i].st, seq[i].vec);
         end
         next_cycle();
      end
      start = 1'b0;
      total++;
      if (instr_count !== 16'd8) begin
         bad++;
         $display("FAIL halt_count: got %0d expected 8", instr_count);
      end
   endtask

   task automatic test_timeout();
      step_t seq [8];
      seq = '{mk(4'd13,0,0,0,3'd1,V_FW), mk(4'd13,0,0,0,3'd1,V_FW), mk(4'd13,0,0,0,3'd1,V_FW),
              mk(4'd13,0,0,0,3'd1,V_FW), mk(4'd13,0,0,0,3'd1,V_FW), mk(4'd13,0,0,0,3'd6,V_HF),
              mk(4'd13,0,0,0,3'd6,V_HF), mk(4'd13,0,0,1,3'd6,V_HF)};
      for (int i = 0; i < 8; i++) begin
         drive(seq[i]);
         @(negedge clk);
         total++;
         if (state_o !== seq[i].st || obs_vec() !== seq[i].vec) begin
            bad++;
            $display("FAIL timeout[%0d]: state=%0d strobes=%b expected state=%0d strobes=%b", i, state_o, obs_vec(), seq[i].st, seq[i].vec);
         end
         next_cycle();
      end
      start = 1'b0;
   endtask

   task automatic test_timeout_ready();
      step_t seq [8];
      seq = '{mk(4'd13,0,0,0,3'd1,V_FW), mk(4'd13,0,0,0,3'd1,V_FW),   mk(4'd13,0,0,0,3'd1,V_FW),
              mk(4'd13,0,0,0,3'd1,V_FW), mk(4'd13,1,0,0,3'd1,V_FR),   mk(4'd13,1,0,0,3'd2,V_NONE),
              mk(4'd13,1,0,0,3'd3,V_ALU), mk(4'd13,1,0,0,3'd5,V_WB)};
      for (int i = 0; i < 8; i++) begin
         drive(seq[i]);
         @(negedge clk);
         total++;
         if (state_o !== seq[i].st || obs_vec() !== seq[i].vec) begin
            bad++;
            $display("FAIL timeout_ready[%0d]: state=%0d strobes=%b expected state=%0d strobes=%b", i, state_o, obs_vec(), seq[i].st, seq[i].vec);
         end
         next_cycle();
      end
      total++;
      if (instr_count !== 16'd9) begin
         bad++;
         $display("FAIL timeout_ready_count: got %0d expected 9", instr_count);
      end
   endtask

   task automatic test_reset_mid_mem();
      step_t seq [3];
      seq = '{mk(4'd3,1,0,0,3'd1,V_FR), mk(4'd3,1,0,0,3'd2,V_NONE), mk(4'd3,1,0,0,3'd3,V_NONE)};
      for (int i = 0; i < 3; i++) begin
         drive(seq[i]);
         @(negedge clk);
         total++;
         if (state_o !== seq[i].st || obs_vec() !== seq[i].vec) begin
            bad++;
            $display("FAIL reset_mid_mem[%0d]: state=%0d strobes=%b expected state=%0d strobes=%b", i, state_o, obs_vec(), seq[i].st, seq[i].vec);
         end
         next_cycle();
      end
      mem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (state_o !== 3'd4 || obs_vec() !== V_ST || instr_count !== 16'd10) begin
         bad++;
         $display("FAIL str_mem: state=%0d strobes=%b count=%0d expected 4/%b/10", state_o, obs_vec(), instr_count, V_ST);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_mem: mem_req=%b mem_we=%b expected 0 0", mem_req, mem_we);
      end
      total++;
      if (state_o !== 3'd0 || instr_count !== 16'd0) begin
         bad++;
         $display("FAIL async_reset_state: state=%0d count=%0d expected 0 0", state_o, instr_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      @(negedge clk);
      total++;
      if (state_o !== 3'd0 || obs_vec() !== V_NONE) begin
         bad++;
         $display("FAIL post_reset_idle: state=%0d strobes=%b expected 0/%b", state_o, obs_vec(), V_NONE);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_store();
      test_branch();
      test_back_to_back();
      test_halt();
      test_timeout();
      test_timeout_ready();
      test_reset_mid_mem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
